// File: rtl/uart_pkg.sv
// Shared types and timing helper for the UART memory dump block.
// State enums for the word controller and the byte serialiser, plus the bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    FINISH
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: a byte accepted on valid&&ready drives its start bit on the next cycle.
// ready is high when idle and in the final cycle of a stop bit, so frames can run back-to-back.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           bit_end;

  assign bit_end = (cnt_q == LAST);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        ready = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          ready   = 1'b1;
          state_d = TX_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // A new byte overrides the idle/stop transition so no idle cycle is inserted.
    if (valid && ready) begin
      state_d = TX_START;
      cnt_d   = '0;
      shift_d = data;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// Streams word_cnt words from a synchronous RAM out of a UART, little-endian, 8N1, no inter-frame gaps.
// First start bit 3 cycles after start is accepted; the next word is prefetched during the previous word's last stop bit.
module uart_mem_dump
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] base_addr,
  input  logic [14:0] word_cnt,
  output logic [13:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int FC_W = $clog2(10 * CPB) + 1;
  // Last cycle before the stop bit of the byte just handed to the serialiser.
  localparam logic [FC_W-1:0] FETCH_AT = FC_W'(9 * CPB - 1);

  ctrl_state_t     state_q, state_d;
  logic [13:0]     mem_addr_q, mem_addr_d;
  logic [14:0]     words_left_q, words_left_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            pend_q, pend_d;
  logic [FC_W-1:0] fc_q, fc_d;

  logic            tx_valid;
  logic            tx_ready;
  logic            tx_accept;
  logic [7:0]      tx_data;

  assign tx_valid  = (state_q == SEND) && pend_q;
  assign tx_accept = tx_valid && tx_ready;
  assign tx_data   = shadow_q[{byte_idx_q, 3'b000} +: 8];

  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    words_left_d = words_left_q;
    shadow_d     = shadow_q;
    byte_idx_d   = byte_idx_q;
    pend_d       = pend_q;
    fc_d         = fc_q + FC_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FETCH;
          mem_addr_d   = base_addr;
          words_left_d = word_cnt;
        end
      end
      FETCH: state_d = (words_left_q == '0) ? FINISH : LOAD;
      LOAD: begin
        // The serialiser already holds the previous byte 3, so the register is free to reload.
        shadow_d     = mem_data;
        byte_idx_d   = 2'd0;
        pend_d       = 1'b1;
        words_left_d = words_left_q - 15'd1;
        state_d      = SEND;
      end
      SEND: begin
        if (tx_accept) begin
          fc_d = '0;
          if (byte_idx_q == 2'd3) begin
            pend_d = 1'b0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (!pend_q) begin
          if (words_left_q == '0) begin
            if (tx_ready) begin
              state_d = FINISH;
            end
          end else if (fc_q == FETCH_AT) begin
            state_d    = FETCH;
            mem_addr_d = mem_addr_q + 14'd1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      words_left_q <= '0;
      shadow_q     <= '0;
      byte_idx_q   <= '0;
      pend_q       <= 1'b0;
      fc_q         <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      words_left_q <= words_left_d;
      shadow_q     <= shadow_d;
      byte_idx_q   <= byte_idx_d;
      pend_q       <= pend_d;
      fc_q         <= fc_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(tx_valid),
    .data (tx_data),
    .ready(tx_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: table of dump requests checked cycle-by-cycle against a byte-stream/waveform model.
module tb_uart_mem_dump;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int NVEC     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] word_cnt = '0;
  logic [13:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:16383];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int base;
    int cnt;
    int spur_j;
    int spur_base;
    int exp_done_j;
    int exp_b0;
  } vec_t;

  vec_t vecs [NVEC];

  uart_mem_dump #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .word_cnt (word_cnt),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_cnt(input string nm, input int bad, input int first);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d samples wrong (first at k+%0d), want 0", nm, bad, first);
    end
  endtask

  // Issues one start, then samples every cycle after the accepting edge k (sample j follows edge k+j).
  task automatic run_dump(input vec_t v, input string nm);
    byte unsigned exp_b[$];
    byte unsigned got_b[$];
    logic         txs[$];
    logic [13:0]  addrs[$];
    logic [31:0]  word;
    logic [7:0]   d;
    logic         exp_t;
    int nbytes, end_j, off, pos, s;
    int bad_tx, f_tx, bad_busy, f_busy, bad_done, f_done, done_at, bad_b, f_b, bad_a, f_a;

    for (int w = 0; w < v.cnt; w++) begin
      word = mem[(v.base + w) % 16384];
      for (int b = 0; b < 4; b++) exp_b.push_back(8'(word >> (8 * b)));
    end
    nbytes = 4 * v.cnt;
    end_j  = (v.cnt == 0) ? 1 : 3 + FRAME * nbytes;
    bad_tx = 0; f_tx = -1; bad_busy = 0; f_busy = -1; bad_done = 0; f_done = -1; done_at = -1;

    @(negedge clk);
    start     = 1'b1;
    base_addr = 14'(v.base);
    word_cnt  = 15'(v.cnt);
    for (int j = 0; j <= end_j + 4; j++) begin
      @(negedge clk);
      if (j >= 3 && j < 3 + FRAME * nbytes) begin
        off   = j - 3;
        pos   = (off % FRAME) / CPB;
        d     = exp_b[off / FRAME];
        exp_t = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : d[pos - 1];
      end else begin
        exp_t = 1'b1;
      end
      txs.push_back(tx);
      if (tx !== exp_t) begin bad_tx++; if (f_tx < 0) f_tx = j; end
      if (busy !== (j < end_j)) begin bad_busy++; if (f_busy < 0) f_busy = j; end
      if (done !== (j == end_j)) begin bad_done++; if (f_done < 0) f_done = j; end
      if (done === 1'b1 && done_at < 0) done_at = j;
      if (j == 0 || mem_addr != addrs[$]) addrs.push_back(mem_addr);
      // Later inputs are scrambled: the dump must run from the values latched at acceptance.
      start     = (j == v.spur_j);
      base_addr = (j == v.spur_j) ? 14'(v.spur_base) : 14'($urandom);
      word_cnt  = 15'($urandom);
    end
    start = 1'b0;

    // Independent receiver: find a falling edge, sample each bit at its centre.
    s = 0;
    while (s + 9 * CPB + CPB / 2 < txs.size()) begin
      if (txs[s] == 1'b0) begin
        for (int i = 0; i < 8; i++) d[i] = txs[s + CPB * (i + 1) + CPB / 2];
        got_b.push_back(d);
        s = s + 9 * CPB + CPB / 2;
      end else begin
        s++;
      end
    end

    bad_b = 0; f_b = -1;
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      if (got_b[i] != exp_b[i]) begin bad_b++; if (f_b < 0) f_b = i; end

    check_cnt({nm, " tx_wave"}, bad_tx, f_tx);
    check_cnt({nm, " busy_wave"}, bad_busy, f_busy);
    check_cnt({nm, " done_wave"}, bad_done, f_done);
    check({nm, " done_cycle"}, done_at, v.exp_done_j);
    check({nm, " nbytes"}, got_b.size(), exp_b.size());
    check_cnt({nm, " byte_values"}, bad_b, f_b);
    if (v.cnt > 0) begin
      check({nm, " byte0"}, (got_b.size() > 0) ? int'(got_b[0]) : -1, v.exp_b0);
      bad_a = 0; f_a = -1;
      for (int i = 0; i < addrs.size() && i < v.cnt; i++)
        if (addrs[i] != 14'((v.base + i) % 16384)) begin bad_a++; if (f_a < 0) f_a = i; end
      check({nm, " addr_n"}, addrs.size(), v.cnt);
      check_cnt({nm, " addr_seq"}, bad_a, f_a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int b, c, bad;

    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[5]     = 32'h12345678;
    mem[0]     = 32'hA5A5A5A5;
    mem[1]     = 32'h0F0F0F0F;
    mem[16383] = 32'hDEADBEEF;

    vecs[0] = '{5,     1, -1,  0, 643,  'h78};
    vecs[1] = '{0,     2, -1,  0, 1283, 'hA5};
    vecs[2] = '{16383, 2, -1,  0, 1283, 'hEF};
    vecs[3] = '{100,   0, -1,  0, 1,    -1};
    vecs[4] = '{5,     1, 300, 9, 643,  'h78};
    for (int i = 5; i < NVEC; i++) begin
      b = int'($urandom_range(0, 16383));
      c = int'($urandom_range(1, 3));
      vecs[i] = '{b, c, int'($urandom_range(0, 3 + 4 * FRAME * c - 1)),
                  int'($urandom_range(0, 16383)), 3 + 4 * FRAME * c, int'(mem[b][7:0])};
    end

    #1 rst_n = 1'b0;
    #2;
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_dump(vecs[i], $sformatf("vec%0d", i));

    // Reset during data bit 3 of byte 1 (0x56 -> bit 3 is 0).
    @(negedge clk);
    start = 1'b1; base_addr = 14'd5; word_cnt = 15'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (233) @(negedge clk);
    check("midrst tx_before", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst tx", tx, 1);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (5 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check_cnt("midrst quiet", bad, 0);
    run_dump(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
